// File: rtl/acc_cpu_if.sv
// Host-side bundle for the accumulator CPU: run handshake, program/data load
// ports and architectural state visibility.
interface acc_cpu_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    localparam int IW = 4 + ADDR_WIDTH;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  prog_wr_en;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [IW-1:0]         prog_data;
    logic                  dbg_wr_en;
    logic                  dbg_rd_en;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic [DATA_WIDTH-1:0] acc;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  zero;
    logic                  carry;

    modport master (
        output start, prog_wr_en, prog_addr, prog_data,
               dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
        input  busy, done, err, dbg_rdata, acc, pc, zero, carry
    );

    modport slave (
        input  start, prog_wr_en, prog_addr, prog_data,
               dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
        output busy, done, err, dbg_rdata, acc, pc, zero, carry
    );
endinterface

// File: rtl/acc_cpu_system.sv
// Accumulator CPU with private instruction and data RAMs, host load/readback
// port usable while idle, start/done handshake and retired-instruction watchdog.
//
// state  | meaning
// IDLE   | host owns both RAMs; waits for start
// FETCH  | imem read issued at pc
// DECODE | instruction word latched into ir
// EXEC   | memory ops issue dmem read; all other opcodes retire here
// WB     | LOAD/ADD/SUB/AND update acc and flags, then retire
// DONE   | one-cycle done pulse, back to IDLE
module acc_cpu_system #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int CYCLE_LIMIT = 256
) (
    input logic     clk,
    input logic     rst,
    acc_cpu_if.slave bus
);
    localparam int IW    = 4 + ADDR_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int RW    = $clog2(CYCLE_LIMIT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic                  zero_q;
    logic                  carry_q;
    logic                  err_q;
    logic [RW-1:0]         retire_left;
    logic [IW-1:0]         ir;
    logic [IW-1:0]         imem_q;
    logic [DATA_WIDTH-1:0] dmem_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;

    logic [IW-1:0]         imem [DEPTH];
    logic [DATA_WIDTH-1:0] dmem [DEPTH];

    logic                  host_idle;
    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;
    logic                  is_mem_op;
    logic                  retire_last;
    logic [ADDR_WIDTH-1:0] exec_pc;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH:0]   diff_ext;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_carry;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_waddr;
    logic [DATA_WIDTH-1:0] dmem_wdata;

    assign host_idle   = (state == S_IDLE);
    assign opcode      = ir[IW-1 -: 4];
    assign operand     = ir[ADDR_WIDTH-1:0];
    assign is_mem_op   = opcode inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND};
    assign retire_last = (retire_left == RW'(1));

    assign sum_ext  = {1'b0, acc_q} + {1'b0, dmem_q};
    assign diff_ext = {1'b0, acc_q} - {1'b0, dmem_q};

    always_comb begin
        exec_pc = pc_q + ADDR_WIDTH'(1);
        case (opcode)
            OP_JMP:  exec_pc = operand;
            OP_JZ:   if (zero_q) exec_pc = operand;
            OP_HALT: exec_pc = pc_q;
            default: ;
        endcase
    end

    always_comb begin
        alu_res   = dmem_q;
        alu_carry = carry_q;
        case (opcode)
            OP_ADD:  {alu_carry, alu_res} = sum_ext;
            OP_SUB:  {alu_carry, alu_res} = diff_ext;
            OP_AND:  alu_res = acc_q & dmem_q;
            default: ;
        endcase
    end

    // A STORE whose EXEC edge coincides with rst must not land.
    always_comb begin
        dmem_we    = 1'b0;
        dmem_waddr = bus.dbg_addr;
        dmem_wdata = bus.dbg_wdata;
        if (host_idle && bus.dbg_wr_en) begin
            dmem_we = 1'b1;
        end else if (state == S_EXEC && opcode == OP_STORE && !rst) begin
            dmem_we    = 1'b1;
            dmem_waddr = operand;
            dmem_wdata = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_q        <= '0;
            acc_q       <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            retire_left <= '0;
            ir          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state       <= S_FETCH;
                        pc_q        <= '0;
                        acc_q       <= '0;
                        zero_q      <= 1'b1;
                        carry_q     <= 1'b0;
                        err_q       <= 1'b0;
                        retire_left <= RW'(CYCLE_LIMIT);
                    end
                end
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir    <= imem_q;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_mem_op) begin
                        state <= S_WB;
                    end else begin
                        pc_q        <= exec_pc;
                        retire_left <= retire_left - RW'(1);
                        if (opcode == OP_LDI) begin
                            acc_q  <= DATA_WIDTH'(operand);
                            zero_q <= (operand == '0);
                        end
                        // HALT wins over the watchdog so a HALT landing on the limit is clean.
                        if (opcode == OP_HALT) begin
                            state <= S_DONE;
                        end else if (retire_last) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    acc_q       <= alu_res;
                    zero_q      <= (alu_res == '0);
                    carry_q     <= alu_carry;
                    pc_q        <= pc_q + ADDR_WIDTH'(1);
                    retire_left <= retire_left - RW'(1);
                    if (retire_last) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (host_idle && bus.prog_wr_en) imem[bus.prog_addr] <= bus.prog_data;
        if (state == S_FETCH) imem_q <= imem[pc_q];
    end

    always_ff @(posedge clk) begin
        if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
        if (state == S_EXEC && is_mem_op) dmem_q <= dmem[operand];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rdata_q <= '0;
        end else if (host_idle && bus.dbg_rd_en) begin
            dbg_rdata_q <= dmem[bus.dbg_addr];
        end
    end

    assign bus.busy      = !host_idle;
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.acc       = acc_q;
    assign bus.pc        = pc_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
endmodule

// File: tb/tb_acc_cpu_system.sv
// Directed bench for acc_cpu_system: table of whole-program runs with hand-computed
// results, plus sequences for host hazards, start/write overlap and mid-run reset.
module tb_acc_cpu_system;
    localparam logic [3:0] NOP = 4'h0, LOAD = 4'h1, STORE = 4'h2, ADD = 4'h3, SUB = 4'h4;
    localparam logic [3:0] AND_ = 4'h5, JMP = 4'h6, JZ = 4'h7, LDI = 4'h8, HALT = 4'hF;
    localparam int NV = 9;

    typedef struct {
        logic [7:0][6:0] prog;
        logic [7:0][7:0] dm;
        logic [7:0]      exp_acc;
        logic            exp_zero;
        logic            exp_carry;
        logic            exp_err;
        int              exp_cyc;
        logic [2:0]      chk_addr;
        logic [7:0]      exp_mem;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    acc_cpu_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    acc_cpu_system #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CYCLE_LIMIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [6:0] ins(input logic [3:0] op, input logic [2:0] a);
        return {op, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input vec_t vv);
        for (int i = 0; i < 8; i++) begin
            bus.prog_wr_en = 1'b1;
            bus.prog_addr  = 3'(i);
            bus.prog_data  = vv.prog[i];
            bus.dbg_wr_en  = 1'b1;
            bus.dbg_addr   = 3'(i);
            bus.dbg_wdata  = vv.dm[i];
            tick();
        end
        bus.prog_wr_en = 1'b0;
        bus.dbg_wr_en  = 1'b0;
    endtask

    task automatic read_dmem(input logic [2:0] addr, output logic [7:0] data);
        bus.dbg_rd_en = 1'b1;
        bus.dbg_addr  = addr;
        tick();
        bus.dbg_rd_en = 1'b0;
        data = bus.dbg_rdata;
    endtask

    task automatic wait_done(inout int cyc);
        while (bus.done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("run_completes", 32'(bus.done), 1);
    endtask

    task automatic start_run(output int cyc);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         cyc;
        logic [7:0] rd;
        bit         saw_done;
        vec_t       rv;

        for (int v = 0; v < NV; v++) begin
            vecs[v].prog = '0;
            vecs[v].dm   = '0;
        end
        // add/store
        vecs[0].prog[0] = ins(LOAD, 0); vecs[0].prog[1] = ins(ADD, 1);
        vecs[0].prog[2] = ins(STORE, 2); vecs[0].prog[3] = ins(HALT, 0);
        vecs[0].dm[0] = 8'd100; vecs[0].dm[1] = 8'd27;
        vecs[0].exp_acc = 8'd127; vecs[0].exp_zero = 0; vecs[0].exp_carry = 0; vecs[0].exp_err = 0;
        vecs[0].exp_cyc = 15; vecs[0].chk_addr = 3'd2; vecs[0].exp_mem = 8'd127;
        // add overflow
        vecs[1].prog[0] = ins(LOAD, 0); vecs[1].prog[1] = ins(ADD, 1); vecs[1].prog[2] = ins(HALT, 0);
        vecs[1].dm[0] = 8'd200; vecs[1].dm[1] = 8'd100;
        vecs[1].exp_acc = 8'd44; vecs[1].exp_zero = 0; vecs[1].exp_carry = 1; vecs[1].exp_err = 0;
        vecs[1].exp_cyc = 12; vecs[1].chk_addr = 3'd1; vecs[1].exp_mem = 8'd100;
        // subtract borrow from zero
        vecs[2].prog[0] = ins(SUB, 1); vecs[2].prog[1] = ins(HALT, 0);
        vecs[2].dm[1] = 8'd1;
        vecs[2].exp_acc = 8'd255; vecs[2].exp_zero = 0; vecs[2].exp_carry = 1; vecs[2].exp_err = 0;
        vecs[2].exp_cyc = 8; vecs[2].chk_addr = 3'd1; vecs[2].exp_mem = 8'd1;
        // AND sets zero, leaves carry from ADD
        vecs[3].prog[0] = ins(LOAD, 0); vecs[3].prog[1] = ins(ADD, 1);
        vecs[3].prog[2] = ins(AND_, 2); vecs[3].prog[3] = ins(HALT, 0);
        vecs[3].dm[0] = 8'hF0; vecs[3].dm[1] = 8'h20; vecs[3].dm[2] = 8'h0F;
        vecs[3].exp_acc = 8'd0; vecs[3].exp_zero = 1; vecs[3].exp_carry = 1; vecs[3].exp_err = 0;
        vecs[3].exp_cyc = 16; vecs[3].chk_addr = 3'd2; vecs[3].exp_mem = 8'h0F;
        // countdown loop from 3 (10 retired)
        vecs[4].prog[0] = ins(LDI, 3); vecs[4].prog[1] = ins(SUB, 7);
        vecs[4].prog[2] = ins(JZ, 4); vecs[4].prog[3] = ins(JMP, 1); vecs[4].prog[4] = ins(HALT, 0);
        vecs[4].dm[7] = 8'd1;
        vecs[4].exp_acc = 8'd0; vecs[4].exp_zero = 1; vecs[4].exp_carry = 0; vecs[4].exp_err = 0;
        vecs[4].exp_cyc = 34; vecs[4].chk_addr = 3'd7; vecs[4].exp_mem = 8'd1;
        // countdown from 5: HALT is exactly the 16th retired instruction
        vecs[5] = vecs[4];
        vecs[5].prog[0] = ins(LDI, 5);
        vecs[5].exp_cyc = 54;
        // pc wrap: JZ skips HALT once, NOPs run off the end, wrap reaches HALT at 1
        vecs[6].prog[0] = ins(JZ, 2); vecs[6].prog[1] = ins(HALT, 0); vecs[6].prog[2] = ins(LDI, 1);
        vecs[6].exp_acc = 8'd1; vecs[6].exp_zero = 0; vecs[6].exp_carry = 0; vecs[6].exp_err = 0;
        vecs[6].exp_cyc = 28; vecs[6].chk_addr = 3'd0; vecs[6].exp_mem = 8'd0;
        // watchdog: JMP 0 forever
        for (int i = 0; i < 8; i++) vecs[7].prog[i] = ins(JMP, 0);
        vecs[7].exp_acc = 8'd0; vecs[7].exp_zero = 1; vecs[7].exp_carry = 0; vecs[7].exp_err = 1;
        vecs[7].exp_cyc = 49; vecs[7].chk_addr = 3'd0; vecs[7].exp_mem = 8'd0;
        // clean run right after watchdog clears err
        vecs[8].prog[0] = ins(LDI, 7); vecs[8].prog[1] = ins(STORE, 3); vecs[8].prog[2] = ins(HALT, 0);
        vecs[8].exp_acc = 8'd7; vecs[8].exp_zero = 0; vecs[8].exp_carry = 0; vecs[8].exp_err = 0;
        vecs[8].exp_cyc = 10; vecs[8].chk_addr = 3'd3; vecs[8].exp_mem = 8'd7;

        bus.start = 0; bus.prog_wr_en = 0; bus.prog_addr = 0; bus.prog_data = 0;
        bus.dbg_wr_en = 0; bus.dbg_rd_en = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_acc", 32'(bus.acc), 0);
        check("rst_pc", 32'(bus.pc), 0);
        check("rst_zero", 32'(bus.zero), 1);
        check("rst_carry", 32'(bus.carry), 0);
        check("rst_rdata", 32'(bus.dbg_rdata), 0);

        for (int v = 0; v < NV; v++) begin
            load_vec(vecs[v]);
            start_run(cyc);
            check($sformatf("v%0d_busy", v), 32'(bus.busy), 1);
            wait_done(cyc);
            check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            check($sformatf("v%0d_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_acc", v), 32'(bus.acc), 32'(vecs[v].exp_acc));
            check($sformatf("v%0d_zero", v), 32'(bus.zero), 32'(vecs[v].exp_zero));
            check($sformatf("v%0d_carry", v), 32'(bus.carry), 32'(vecs[v].exp_carry));
            tick();
            tick();
            check($sformatf("v%0d_idle", v), 32'(bus.busy), 0);
            check($sformatf("v%0d_err_hold", v), 32'(bus.err), 32'(vecs[v].exp_err));
            read_dmem(vecs[v].chk_addr, rd);
            check($sformatf("v%0d_mem", v), 32'(rd), 32'(vecs[v].exp_mem));
        end

        // host read-during-write returns the old word
        bus.dbg_wr_en = 1; bus.dbg_addr = 3'd4; bus.dbg_wdata = 8'h11;
        tick();
        bus.dbg_rd_en = 1; bus.dbg_wdata = 8'h22;
        tick();
        bus.dbg_wr_en = 0; bus.dbg_rd_en = 0;
        check("rdw_old", 32'(bus.dbg_rdata), 32'h11);
        read_dmem(3'd4, rd);
        check("rdw_new", 32'(rd), 32'h22);

        // start, host writes and host read during busy are all ignored
        load_vec(vecs[0]);
        read_dmem(3'd0, rd);
        check("pre_busy_rdata", 32'(rd), 100);
        start_run(cyc);
        tick(); cyc++;
        tick(); cyc++;
        bus.start = 1; bus.prog_wr_en = 1; bus.prog_addr = 3'd3; bus.prog_data = ins(NOP, 0);
        bus.dbg_wr_en = 1; bus.dbg_addr = 3'd0; bus.dbg_wdata = 8'd55;
        tick(); cyc++;
        bus.start = 0; bus.prog_wr_en = 0; bus.dbg_wr_en = 0;
        bus.dbg_rd_en = 1; bus.dbg_addr = 3'd1;
        tick(); cyc++;
        bus.dbg_rd_en = 0;
        check("busy_rdata_hold", 32'(bus.dbg_rdata), 100);
        wait_done(cyc);
        check("busy_cycles", 32'(cyc), 15);
        check("busy_acc", 32'(bus.acc), 127);
        check("busy_err", 32'(bus.err), 0);
        tick();
        read_dmem(3'd0, rd);
        check("busy_mem0", 32'(rd), 100);

        // start together with a program write: fetch sees the new word
        bus.prog_wr_en = 1; bus.prog_addr = 3'd0; bus.prog_data = ins(JMP, 0);
        tick();
        bus.prog_data = ins(HALT, 0);
        bus.start = 1;
        tick();
        bus.start = 0; bus.prog_wr_en = 0;
        cyc = 1;
        wait_done(cyc);
        check("startwr_cycles", 32'(cyc), 4);
        check("startwr_err", 32'(bus.err), 0);
        tick();

        // reset during STORE's EXEC cycle (cycle 11 of the run)
        rv.prog = '0; rv.dm = '0;
        rv.prog[0] = ins(LOAD, 3); rv.prog[1] = ins(ADD, 4);
        rv.prog[2] = ins(STORE, 5); rv.prog[3] = ins(HALT, 0);
        rv.dm[3] = 8'd5; rv.dm[4] = 8'd6;
        rv.exp_acc = 0; rv.exp_zero = 0; rv.exp_carry = 0; rv.exp_err = 0;
        rv.exp_cyc = 0; rv.chk_addr = 0; rv.exp_mem = 0;
        load_vec(rv);
        start_run(cyc);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) saw_done = 1;
            tick();
        end
        if (bus.done === 1'b1) saw_done = 1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (bus.done === 1'b1) saw_done = 1;
        check("rstmid_busy", 32'(bus.busy), 0);
        check("rstmid_no_done", 32'(saw_done), 0);
        check("rstmid_acc", 32'(bus.acc), 0);
        tick();
        check("rstmid_no_done_after", 32'(bus.done), 0);
        read_dmem(3'd5, rd);
        check("rstmid_no_store", 32'(rd), 0);
        start_run(cyc);
        wait_done(cyc);
        check("restart_cycles", 32'(cyc), 15);
        check("restart_acc", 32'(bus.acc), 11);
        tick();
        read_dmem(3'd5, rd);
        check("restart_mem", 32'(rd), 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
